activation_sequencer: RTL and testbench

- Sequences the shared combinational activation units (Sigmoid, ReLU) that sit behind the systolic array.
- Takes one tile of SA_LENGTH-wide result rows from the array over a valid/ready handshake.
- For each row, selects the activation function latched at start, gates the unit enable, and registers the activated row into a one-entry output stage.
- Counts rows per tile and pulses done when the last row has been consumed downstream.

---
 rtl/activation_sequencer.sv | 124 ++++++++++++
 tb/tb_activation_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/activation_sequencer.sv
// Row sequencer for the shared Sigmoid/ReLU units behind the systolic array.
// Accepts a tile of rows, selects the latched activation and registers each result.
module activation_sequencer #(
    parameter int unsigned DATA_WIDTH = 12,
    parameter int unsigned SA_LENGTH  = 7,
    parameter int unsigned S          = 7,
    parameter int unsigned ROW_CNT_W  = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [1:0]                      mode,
    input  logic [ROW_CNT_W-1:0]            num_rows,
    output logic                            busy,
    output logic                            done,
    input  logic [SA_LENGTH*DATA_WIDTH-1:0] in_row,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [SA_LENGTH*DATA_WIDTH-1:0] act_in,
    output logic                            act_relu_en,
    output logic                            act_sig_en,
    input  logic [SA_LENGTH*DATA_WIDTH-1:0] relu_out,
    input  logic [SA_LENGTH*DATA_WIDTH-1:0] sig_out,
    output logic [SA_LENGTH*DATA_WIDTH-1:0] out_row,
    output logic                            out_valid,
    input  logic                            out_ready
);

    // The fraction width only matters to the activation units; reject nonsense at elaboration.
    if (S >= DATA_WIDTH) begin : g_bad_frac
        $error("fraction bits must be narrower than the element width");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e                          state_q, state_d;
    logic [1:0]                      mode_q, mode_d;
    logic [ROW_CNT_W-1:0]            num_rows_q, num_rows_d;
    logic [ROW_CNT_W-1:0]            cnt_q, cnt_d;
    logic [SA_LENGTH*DATA_WIDTH-1:0] out_row_q;
    logic                            out_valid_q;
    logic [SA_LENGTH*DATA_WIDTH-1:0] act_row;
    logic                            accept;

    assign in_ready    = (state_q == StRun) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q == StRun) || (state_q == StDrain);
    assign done        = (state_q == StDone);
    assign act_in      = in_row;
    assign act_sig_en  = accept && (mode_q == 2'd2);
    assign act_relu_en = accept && (mode_q == 2'd1);
    assign out_row     = out_row_q;
    assign out_valid   = out_valid_q;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        num_rows_d = num_rows_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mode_d     = mode;
                    num_rows_d = num_rows;
                    cnt_d      = '0;
                    state_d    = (num_rows != '0) ? StRun : StDone;
                end
            end
            StRun: begin
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == num_rows_q - 1'b1) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_valid_q && out_ready) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Reserved mode 3 falls through to bypass.
    always_comb begin
        act_row = in_row;
        unique case (mode_q)
            2'd1:    act_row = relu_out;
            2'd2:    act_row = sig_out;
            default: act_row = in_row;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            mode_q     <= 2'd0;
            num_rows_q <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            num_rows_q <= num_rows_d;
            cnt_q      <= cnt_d;
        end
    end

    // Single-entry output stage; a new accept may refill it in the cycle it drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_row_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_row_q   <= act_row;
            out_valid_q <= 1'b1;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_activation_sequencer.sv
// Self-checking bench for activation_sequencer: vector table plus hand-written
// multi-cycle sequences, with a scoreboard queue for the output stream.
module tb_activation_sequencer;

    localparam int DW = 12;
    localparam int L  = 7;
    typedef logic [L*DW-1:0] row_t;

    typedef struct {
        logic [1:0] mode;
        int         inc;
        int         off;
        bit         sig;
        bit         relu;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] num_rows = 8'd0;
    logic       busy, done, in_ready, act_relu_en, act_sig_en, out_valid;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    row_t       in_row = '0;
    row_t       act_in, relu_out, sig_out, out_row;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    row_t exp_q[$];
    logic [1:0] tile_mode = 2'd0;
    int   out_hs = 0, acc_cnt = 0, done_cnt = 0;
    int   done_cyc = 0, last_acc_cyc = 0, last_hs_cyc = 0;
    int   hs0 = 0, a0 = 0;
    bit   prev_acc = 1'b0;

    activation_sequencer #(
        .DATA_WIDTH(DW),
        .SA_LENGTH (L),
        .S         (7),
        .ROW_CNT_W (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .mode       (mode),
        .num_rows   (num_rows),
        .busy       (busy),
        .done       (done),
        .in_row     (in_row),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .act_in     (act_in),
        .act_relu_en(act_relu_en),
        .act_sig_en (act_sig_en),
        .relu_out   (relu_out),
        .sig_out    (sig_out),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic row_t row_add(input row_t r, input int k);
        row_t o;
        o = '0;
        for (int i = 0; i < L; i++) o[i*DW +: DW] = r[i*DW +: DW] + k[DW-1:0];
        return o;
    endfunction

    function automatic row_t model(input logic [1:0] m, input row_t r);
        case (m)
            2'd1:    return row_add(r, 9);
            2'd2:    return row_add(r, 5);
            default: return r;
        endcase
    endfunction

    function automatic row_t mk_base();
        int   vals[L] = '{0, 400, 517, -512, -1, -2048, 2047};
        row_t o;
        o = '0;
        for (int i = 0; i < L; i++) o[i*DW +: DW] = vals[i][DW-1:0];
        return o;
    endfunction

    // Stand-in activation units.
    assign sig_out  = row_add(in_row, 5);
    assign relu_out = row_add(in_row, 9);

    task automatic check(input bit ok, input string name, input row_t act, input row_t exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin : mon
        logic acc;
        row_t e;
        if (rst_n) begin
            acc = in_valid && in_ready;
            if (prev_acc) check(out_valid == 1'b1, "latency", row_t'(out_valid), 1);
            if (out_valid && out_ready) begin
                out_hs++;
                last_hs_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_output", out_row, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_row == e, "scoreboard_row", out_row, e);
                end
            end
            check(act_sig_en == (acc && tile_mode == 2'd2), "sig_en", row_t'(act_sig_en),
                  row_t'(acc && tile_mode == 2'd2));
            check(act_relu_en == (acc && tile_mode == 2'd1), "relu_en", row_t'(act_relu_en),
                  row_t'(acc && tile_mode == 2'd1));
            check(act_in == in_row, "act_in", act_in, in_row);
            if (acc) begin
                exp_q.push_back(model(tile_mode, in_row));
                acc_cnt++;
                last_acc_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_acc = acc;
        end else begin
            exp_q.delete();
            prev_acc = 1'b0;
        end
    end

    task automatic start_tile(input logic [1:0] m, input logic [7:0] n);
        start = 1'b1;
        mode = m;
        num_rows = n;
        tile_mode = m;
        hs0 = out_hs;
        a0 = acc_cnt;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~m;
        num_rows = n + 8'd3;
    endtask

    task automatic send_row(input row_t r, input string name);
        bit ok;
        ok = 1'b0;
        in_row = r;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) check(1'b0, {name, "_accept_timeout"}, 0, 1);
    endtask

    task automatic wait_done(input string name, input int budget);
        int d0;
        bit seen;
        d0 = done_cnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(posedge clk); #1;
            if (done_cnt != d0) seen = 1'b1;
        end
        check(seen, {name, "_done"}, row_t'(seen), 1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t tbl[4];
        row_t base, r, r0, held;
        int   d0;
        tbl[0] = '{mode: 2'd0, inc: 3,  off: 0, sig: 1'b0, relu: 1'b0};
        tbl[1] = '{mode: 2'd1, inc: 7,  off: 9, sig: 1'b0, relu: 1'b1};
        tbl[2] = '{mode: 2'd2, inc: 11, off: 5, sig: 1'b1, relu: 1'b0};
        tbl[3] = '{mode: 2'd3, inc: 13, off: 0, sig: 1'b0, relu: 1'b0};
        base = mk_base();

        // Reset state
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        check({busy, done, out_valid, in_ready, act_sig_en, act_relu_en} == 6'b0,
              "reset_ctrl", row_t'({busy, done, out_valid, in_ready, act_sig_en, act_relu_en}), 0);
        check(out_row == '0, "reset_out_row", out_row, 0);
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Bypass tile of three rows
        start_tile(2'd0, 8'd3);
        check(busy == 1'b1, "bypass_busy", row_t'(busy), 1);
        for (int k = 0; k < 3; k++) send_row(row_add(base, k), "bypass");
        wait_done("bypass", 20);
        check(done_cyc - last_hs_cyc == 1, "bypass_done_timing", row_t'(done_cyc - last_hs_cyc), 1);
        check(out_hs - hs0 == 3, "bypass_hs", row_t'(out_hs - hs0), 3);

        // Activation select table, one-row tiles
        foreach (tbl[j]) begin
            start_tile(tbl[j].mode, 8'd1);
            r = row_add(base, tbl[j].inc);
            in_row = r;
            in_valid = 1'b1;
            @(negedge clk);
            check(act_sig_en == tbl[j].sig, "tbl_sig_en", row_t'(act_sig_en), row_t'(tbl[j].sig));
            check(act_relu_en == tbl[j].relu, "tbl_relu_en", row_t'(act_relu_en),
                  row_t'(tbl[j].relu));
            @(posedge clk); #1;
            in_valid = 1'b0;
            @(negedge clk);
            check(out_valid == 1'b1, "tbl_out_valid", row_t'(out_valid), 1);
            check(out_row == row_add(r, tbl[j].off), "tbl_out_row", out_row, row_add(r, tbl[j].off));
            wait_done("tbl", 10);
        end

        // Backpressure: ReLU, four rows, stall three cycles after the first accept
        start_tile(2'd1, 8'd4);
        r0 = row_add(base, 30);
        send_row(r0, "bp0");
        out_ready = 1'b0;
        in_row = row_add(base, 31);
        in_valid = 1'b1;
        held = row_add(r0, 9);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check(in_ready == 1'b0, "bp_in_ready", row_t'(in_ready), 0);
            check(out_valid == 1'b1, "bp_out_valid", row_t'(out_valid), 1);
            check(out_row == held, "bp_out_row_stable", out_row, held);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        for (int k = 1; k < 4; k++) send_row(row_add(base, 30 + k), "bp");
        wait_done("bp", 20);
        check(out_hs - hs0 == 4, "bp_hs", row_t'(out_hs - hs0), 4);
        check(acc_cnt - a0 == 4, "bp_accepts", row_t'(acc_cnt - a0), 4);

        // Zero-row tile
        start = 1'b1;
        mode = 2'd0;
        num_rows = 8'd0;
        tile_mode = 2'd0;
        @(negedge clk);
        check(busy == 1'b0, "zero_busy0", row_t'(busy), 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check({done, busy} == 2'b10, "zero_done", row_t'({done, busy}), row_t'(2'b10));
        @(posedge clk); #1;
        @(negedge clk);
        check({done, busy} == 2'b00, "zero_after", row_t'({done, busy}), 0);
        @(posedge clk); #1;

        // Start while running is ignored: mode and counter stay
        start_tile(2'd2, 8'd2);
        send_row(row_add(base, 40), "ign0");
        start = 1'b1;
        mode = 2'd0;
        num_rows = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send_row(row_add(base, 41), "ign1");
        wait_done("ign", 10);
        check(acc_cnt - a0 == 2, "ign_accepts", row_t'(acc_cnt - a0), 2);

        // Asynchronous reset mid-tile
        start_tile(2'd1, 8'd5);
        send_row(row_add(base, 50), "rst0");
        send_row(row_add(base, 51), "rst1");
        in_row = row_add(base, 52);
        in_valid = 1'b1;
        d0 = done_cnt;
        #2;
        rst_n = 1'b0;
        #1;
        check({busy, out_valid, in_ready, done} == 4'b0, "rst_async",
              row_t'({busy, out_valid, in_ready, done}), 0);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(done_cnt == d0, "rst_no_done", row_t'(done_cnt), row_t'(d0));
        check(busy == 1'b0, "rst_idle", row_t'(busy), 0);
        start_tile(2'd0, 8'd2);
        send_row(row_add(base, 60), "post0");
        send_row(row_add(base, 61), "post1");
        wait_done("post", 10);
        check(out_hs - hs0 == 2, "post_hs", row_t'(out_hs - hs0), 2);

        // Full throughput, six rows back to back
        start_tile(2'd0, 8'd6);
        out_ready = 1'b1;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            in_row = row_add(base, 70 + k);
            @(negedge clk);
            check(in_ready == 1'b1, "tp_in_ready", row_t'(in_ready), 1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check(acc_cnt - a0 == 6, "tp_accepts", row_t'(acc_cnt - a0), 6);
        wait_done("tp", 10);
        check(done_cyc - last_acc_cyc == 2, "tp_done_timing", row_t'(done_cyc - last_acc_cyc), 2);
        check(exp_q.size() == 0, "scoreboard_empty", row_t'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
